// File: rtl/fractal_pixel_engine_if.sv
// ---------------------------------------------------------------------------
// fractal_pixel_engine_if
//   Pixel result stream between the fractal engine and the colour-map/packer.
//   master : the engine (drives results, samples out_ready)
//   slave  : the downstream consumer (samples results, drives out_ready)
//   Signals:
//     out_valid  - pixel result available
//     out_ready  - downstream accept
//     out_iter   - iteration count, 0..MAX_ITER
//     out_in_set - count reached MAX_ITER
//     out_sof    - pixel is (0,0)
//     out_eol    - pixel is the last of its line
//     out_x/y    - pixel coordinate
// ---------------------------------------------------------------------------
interface fractal_pixel_engine_if #(
   parameter int ITER_W = 8,
   parameter int X_W    = 10,
   parameter int Y_W    = 9
);
   logic              out_valid;
   logic              out_ready;
   logic [ITER_W-1:0] out_iter;
   logic              out_in_set;
   logic              out_sof;
   logic              out_eol;
   logic [X_W-1:0]    out_x;
   logic [Y_W-1:0]    out_y;

   modport master (
      output out_valid, out_iter, out_in_set, out_sof, out_eol, out_x, out_y,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_iter, out_in_set, out_sof, out_eol, out_x, out_y,
      output out_ready
   );
endinterface

// File: rtl/fractal_pixel_engine.sv
// ---------------------------------------------------------------------------
// fractal_pixel_engine
//   Escape-time fractal engine (Mandelbrot or Julia, selected per frame).
//   Walks an X_SIZE x Y_SIZE raster and emits one iteration count per pixel
//   on a valid/ready stream.
//   Ports:
//     out_stream_aclk  - sole clock, rising edge
//     periph_reset     - synchronous active-high reset
//     run              - frame enable, sampled only while idle
//     cfg_mode         - 0 Mandelbrot (c = pixel, z0 = 0), 1 Julia (z0 = pixel)
//     cfg_re0/cfg_im0  - coordinate of pixel (0,0)
//     cfg_step_re/im   - per-x real step / per-y imaginary step
//     cfg_c_re/cfg_c_im- Julia constant
//     out_if           - pixel result stream (master side)
//     busy             - high whenever not idle
//     frame_done       - one-cycle pulse in the cycle the last pixel is accepted
//   All fixed-point values are signed DATA_W with FRAC_BITS fractional bits.
// ---------------------------------------------------------------------------
module fractal_pixel_engine #(
   parameter int X_SIZE    = 640,
   parameter int Y_SIZE    = 480,
   parameter int MAX_ITER  = 100,
   parameter int DATA_W    = 32,
   parameter int FRAC_BITS = 8,
   parameter int ITER_W    = 8
) (
   input  logic                     out_stream_aclk,
   input  logic                     periph_reset,
   input  logic                     run,
   input  logic                     cfg_mode,
   input  logic signed [DATA_W-1:0] cfg_re0,
   input  logic signed [DATA_W-1:0] cfg_im0,
   input  logic signed [DATA_W-1:0] cfg_step_re,
   input  logic signed [DATA_W-1:0] cfg_step_im,
   input  logic signed [DATA_W-1:0] cfg_c_re,
   input  logic signed [DATA_W-1:0] cfg_c_im,
   fractal_pixel_engine_if.master   out_if,
   output logic                     busy,
   output logic                     frame_done
);

   localparam int X_W = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
   localparam int Y_W = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
   localparam int PW  = 2 * DATA_W;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_ITER  = 2'd2;
   localparam logic [1:0] S_OUT   = 2'd3;

   // |z|^2 escape threshold (4.0 at the squared scale, 2*FRAC_BITS fraction bits)
   localparam logic [PW:0]       ESC_LIMIT = (PW+1)'(4) << (2 * FRAC_BITS);
   localparam logic [ITER_W-1:0] ITER_MAX  = ITER_W'(MAX_ITER);
   localparam logic [X_W-1:0]    X_LAST    = X_W'(X_SIZE - 1);
   localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(Y_SIZE - 1);

   logic [1:0]               state_q,   state_d;
   logic [X_W-1:0]           x_q,       x_d;
   logic [Y_W-1:0]           y_q,       y_d;
   logic [ITER_W-1:0]        iter_q,    iter_d;
   logic signed [DATA_W-1:0] zr_q,      zr_d;
   logic signed [DATA_W-1:0] zi_q,      zi_d;
   logic signed [DATA_W-1:0] cr_q,      cr_d;
   logic signed [DATA_W-1:0] ci_q,      ci_d;
   logic signed [DATA_W-1:0] cur_re_q,  cur_re_d;
   logic signed [DATA_W-1:0] cur_im_q,  cur_im_d;
   // Per-frame shadow copies of the configuration
   logic                     mode_q,    mode_d;
   logic signed [DATA_W-1:0] re0_q,     re0_d;
   logic signed [DATA_W-1:0] step_re_q, step_re_d;
   logic signed [DATA_W-1:0] step_im_q, step_im_d;
   logic signed [DATA_W-1:0] jc_re_q,   jc_re_d;
   logic signed [DATA_W-1:0] jc_im_q,   jc_im_d;

   // ------------------------------------------------------------------
   // Iteration datapath: full-width squares, escape test, z update
   // ------------------------------------------------------------------
   logic signed [PW-1:0]     zr_w, zi_w;
   logic signed [PW-1:0]     zr2, zi2, zri, diff;
   logic signed [PW:0]       cross2;
   logic [PW:0]              mag;
   logic                     escape;
   logic signed [DATA_W-1:0] zr_new, zi_new;
   logic                     last_x, last_px, accept;

   assign zr_w   = {{DATA_W{zr_q[DATA_W-1]}}, zr_q};
   assign zi_w   = {{DATA_W{zi_q[DATA_W-1]}}, zi_q};
   assign zr2    = zr_w * zr_w;
   assign zi2    = zi_w * zi_w;
   assign zri    = zr_w * zi_w;
   // Squares are never negative, so one extra bit keeps the sum exact
   assign mag    = {1'b0, zr2} + {1'b0, zi2};
   assign escape = (mag > ESC_LIMIT);
   assign diff   = zr2 - zi2;
   // 2*zr*zi needs one bit more than the product to avoid wrapping early
   assign cross2 = $signed({zri, 1'b0});
   assign zr_new = DATA_W'(diff >>> FRAC_BITS) + cr_q;
   assign zi_new = DATA_W'(cross2 >>> FRAC_BITS) + ci_q;

   assign last_x  = (x_q == X_LAST);
   assign last_px = last_x && (y_q == Y_LAST);
   assign accept  = (state_q == S_OUT) && out_if.out_ready;

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      iter_d    = iter_q;
      zr_d      = zr_q;
      zi_d      = zi_q;
      cr_d      = cr_q;
      ci_d      = ci_q;
      cur_re_d  = cur_re_q;
      cur_im_d  = cur_im_q;
      mode_d    = mode_q;
      re0_d     = re0_q;
      step_re_d = step_re_q;
      step_im_d = step_im_q;
      jc_re_d   = jc_re_q;
      jc_im_d   = jc_im_q;

      case (state_q)
         S_IDLE: begin
            if (run) begin
               mode_d    = cfg_mode;
               re0_d     = cfg_re0;
               step_re_d = cfg_step_re;
               step_im_d = cfg_step_im;
               jc_re_d   = cfg_c_re;
               jc_im_d   = cfg_c_im;
               cur_re_d  = cfg_re0;
               cur_im_d  = cfg_im0;
               state_d   = S_START;
            end
         end

         S_START: begin
            iter_d = '0;
            if (mode_q) begin
               zr_d = cur_re_q;
               zi_d = cur_im_q;
               cr_d = jc_re_q;
               ci_d = jc_im_q;
            end else begin
               zr_d = '0;
               zi_d = '0;
               cr_d = cur_re_q;
               ci_d = cur_im_q;
            end
            state_d = S_ITER;
         end

         S_ITER: begin
            // Escape is tested on the current z, before any update
            if (escape || (iter_q == ITER_MAX)) begin
               state_d = S_OUT;
            end else begin
               zr_d   = zr_new;
               zi_d   = zi_new;
               iter_d = iter_q + ITER_W'(1);
            end
         end

         default: begin   // S_OUT
            if (out_if.out_ready) begin
               if (last_px) begin
                  x_d     = '0;
                  y_d     = '0;
                  state_d = S_IDLE;
               end else if (last_x) begin
                  x_d      = '0;
                  y_d      = y_q + Y_W'(1);
                  cur_re_d = re0_q;
                  cur_im_d = cur_im_q + step_im_q;
                  state_d  = S_START;
               end else begin
                  x_d      = x_q + X_W'(1);
                  cur_re_d = cur_re_q + step_re_q;
                  state_d  = S_START;
               end
            end
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge out_stream_aclk) begin
      if (periph_reset) begin
         state_q   <= S_IDLE;
         x_q       <= '0;
         y_q       <= '0;
         iter_q    <= '0;
         zr_q      <= '0;
         zi_q      <= '0;
         cr_q      <= '0;
         ci_q      <= '0;
         cur_re_q  <= '0;
         cur_im_q  <= '0;
         mode_q    <= 1'b0;
         re0_q     <= '0;
         step_re_q <= '0;
         step_im_q <= '0;
         jc_re_q   <= '0;
         jc_im_q   <= '0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         iter_q    <= iter_d;
         zr_q      <= zr_d;
         zi_q      <= zi_d;
         cr_q      <= cr_d;
         ci_q      <= ci_d;
         cur_re_q  <= cur_re_d;
         cur_im_q  <= cur_im_d;
         mode_q    <= mode_d;
         re0_q     <= re0_d;
         step_re_q <= step_re_d;
         step_im_q <= step_im_d;
         jc_re_q   <= jc_re_d;
         jc_im_q   <= jc_im_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs: flags are qualified by out_valid so they read 0 when idle
   // ------------------------------------------------------------------
   assign out_if.out_valid  = (state_q == S_OUT);
   assign out_if.out_iter   = iter_q;
   assign out_if.out_in_set = (state_q == S_OUT) && (iter_q == ITER_MAX);
   assign out_if.out_sof    = (state_q == S_OUT) && (x_q == '0) && (y_q == '0);
   assign out_if.out_eol    = (state_q == S_OUT) && last_x;
   assign out_if.out_x      = x_q;
   assign out_if.out_y      = y_q;
   assign busy              = (state_q != S_IDLE);
   assign frame_done        = accept && last_px;

endmodule

// File: tb/tb_fractal_pixel_engine.sv
// ---------------------------------------------------------------------------
// tb_fractal_pixel_engine
//   Directed test of fractal_pixel_engine on a 4x3 raster. Stimulus pushes
//   hand-computed per-pixel results into a queue; a negedge monitor pops and
//   compares on every accepted pixel.
// ---------------------------------------------------------------------------
module tb_fractal_pixel_engine;

   localparam int X_SIZE    = 4;
   localparam int Y_SIZE    = 3;
   localparam int MAX_ITER  = 100;
   localparam int DATA_W    = 32;
   localparam int FRAC_BITS = 8;
   localparam int ITER_W    = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                     srst;
   logic                     run;
   logic                     cfg_mode;
   logic signed [DATA_W-1:0] cfg_re0, cfg_im0, cfg_step_re, cfg_step_im, cfg_c_re, cfg_c_im;
   logic                     busy;
   logic                     frame_done;

   fractal_pixel_engine_if #(.ITER_W(ITER_W), .X_W(2), .Y_W(2)) out_if ();

   fractal_pixel_engine #(
      .X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE), .MAX_ITER(MAX_ITER),
      .DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS), .ITER_W(ITER_W)
   ) dut (
      .out_stream_aclk (clk),
      .periph_reset    (srst),
      .run             (run),
      .cfg_mode        (cfg_mode),
      .cfg_re0         (cfg_re0),
      .cfg_im0         (cfg_im0),
      .cfg_step_re     (cfg_step_re),
      .cfg_step_im     (cfg_step_im),
      .cfg_c_re        (cfg_c_re),
      .cfg_c_im        (cfg_c_im),
      .out_if          (out_if),
      .busy            (busy),
      .frame_done      (frame_done)
   );

   typedef struct packed {
      logic [1:0] x;
      logic [1:0] y;
      logic [7:0] iter;
      logic       in_set;
      logic       sof;
      logic       eol;
      logic       last;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
      end
   endtask

   task automatic push_frame(input int it [0:11]);
      exp_t e;
      for (int i = 0; i < 12; i++) begin
         e.x      = 2'(i % 4);
         e.y      = 2'(i / 4);
         e.iter   = 8'(it[i]);
         e.in_set = (it[i] == MAX_ITER);
         e.sof    = (i == 0);
         e.eol    = ((i % 4) == 3);
         e.last   = (i == 11);
         exp_q.push_back(e);
      end
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      exp_t e;
      exp_t g;
      if (!srst && out_if.out_valid && out_if.out_ready) begin
         g = {out_if.out_x, out_if.out_y, out_if.out_iter, out_if.out_in_set,
              out_if.out_sof, out_if.out_eol, frame_done};
         if (exp_q.size() == 0) begin
            check("unexpected_pixel", 64'(g), 64'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check("pixel", 64'(g), 64'(e));
         end
         $display("pixel x=%0d y=%0d iter=%0d in_set=%0d sof=%0d eol=%0d done=%0d",
                  g.x, g.y, g.iter, g.in_set, g.sof, g.eol, g.last);
      end
   end

   task automatic wait_busy();
      bit ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (busy) begin ok = 1'b1; break; end
      end
      check("busy_rise", 64'(ok), 64'd1);
   endtask

   task automatic start_single_frame();
      run = 1'b1;
      wait_busy();
      run = 1'b0;
   endtask

   task automatic wait_frame_done();
      bit seen = 1'b0;
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         if (frame_done) begin seen = 1'b1; break; end
      end
      check("frame_done_seen", 64'(seen), 64'd1);
   endtask

   task automatic idle_check();
      bit ok = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (busy || out_if.out_valid) ok = 1'b0;
      end
      check("idle_after_frame", 64'(ok), 64'd1);
   endtask

   task automatic set_cfg(input logic mode, input int re0, input int im0,
                          input int sre, input int sim, input int cre, input int cim);
      cfg_mode    = mode;
      cfg_re0     = re0;
      cfg_im0     = im0;
      cfg_step_re = sre;
      cfg_step_im = sim;
      cfg_c_re    = cre;
      cfg_c_im    = cim;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  all100 [0:11];
      int  all1   [0:11];
      int  all0   [0:11];
      int  mand   [0:11];
      int  julia  [0:11];
      int  lat;
      bit  ok;
      exp_t e;
      logic [15:0] snap;

      all100 = '{100,100,100,100,100,100,100,100,100,100,100,100};
      all1   = '{1,1,1,1,1,1,1,1,1,1,1,1};
      all0   = '{0,0,0,0,0,0,0,0,0,0,0,0};
      // Grid re in {-2,-1,0,1}, im in {-1,0,1}
      mand   = '{1,3,100,2, 100,100,100,3, 1,3,100,2};
      julia  = '{0,2,100,2, 1,100,100,100, 0,2,100,2};

      srst = 1'b1;
      run  = 1'b0;
      out_if.out_ready = 1'b1;
      set_cfg(1'b0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      check("reset_state",
            64'({out_if.out_valid, busy, frame_done, out_if.out_in_set, out_if.out_sof,
                 out_if.out_eol, out_if.out_iter, out_if.out_x, out_if.out_y}), 64'd0);
      srst = 1'b0;

      // T1: reset while pixel (1,0) is iterating (c = 0, in set, long)
      set_cfg(1'b0, 512, 0, -512, 0, 0, 0);
      e = '{x:2'd0, y:2'd0, iter:8'd2, in_set:1'b0, sof:1'b1, eol:1'b0, last:1'b0};
      exp_q.push_back(e);
      start_single_frame();
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (out_if.out_x == 2'd1) begin ok = 1'b1; break; end
      end
      check("t1_reach_x1", 64'(ok), 64'd1);
      repeat (20) @(posedge clk);
      #1 srst = 1'b1;
      repeat (3) @(posedge clk);
      #1 srst = 1'b0;
      @(posedge clk); #1;
      check("t1_after_reset",
            64'({out_if.out_valid, busy, frame_done, out_if.out_x, out_if.out_y}), 64'd0);
      check("t1_queue_empty", 64'(exp_q.size()), 64'd0);

      // T2: origin, every pixel in set; first result 102 cycles after START
      set_cfg(1'b0, 0, 0, 0, 0, 0, 0);
      push_frame(all100);
      start_single_frame();
      lat = 0;
      while (!out_if.out_valid && lat < 500) begin
         @(posedge clk); #1;
         lat++;
      end
      check("t2_latency", 64'(lat), 64'd102);
      wait_frame_done();
      idle_check();

      // T5: Mandelbrot grid, config changed mid-frame and picked up by the next frame
      set_cfg(1'b0, -512, -256, 256, 256, 0, 0);
      push_frame(mand);
      push_frame(all1);
      run = 1'b1;
      wait_busy();
      repeat (50) @(posedge clk);
      #1 set_cfg(1'b0, 512, 512, 0, 0, 0, 0);
      wait_frame_done();
      @(posedge clk);
      @(posedge clk); #1;
      run = 1'b0;
      check("t5_restart_busy", 64'(busy), 64'd1);
      wait_frame_done();
      idle_check();

      // T3: Julia with z0 = 2+2i already outside the escape circle
      @(posedge clk); #1;
      set_cfg(1'b1, 512, 512, 0, 0, 0, 0);
      push_frame(all0);
      start_single_frame();
      wait_frame_done();

      // T4: Julia grid (c = 0) with first pixel held by back-pressure
      @(posedge clk); #1;
      set_cfg(1'b1, -512, -256, 256, 256, 0, 0);
      push_frame(julia);
      out_if.out_ready = 1'b0;
      start_single_frame();
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (out_if.out_valid) begin ok = 1'b1; break; end
      end
      check("t4_valid_seen", 64'(ok), 64'd1);
      snap = {out_if.out_valid, out_if.out_iter, out_if.out_in_set, out_if.out_sof,
              out_if.out_eol, out_if.out_x, out_if.out_y};
      ok = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if ({out_if.out_valid, out_if.out_iter, out_if.out_in_set, out_if.out_sof,
              out_if.out_eol, out_if.out_x, out_if.out_y} !== snap || !out_if.out_valid)
            ok = 1'b0;
      end
      check("t4_stable_under_backpressure", 64'(ok), 64'd1);
      @(posedge clk); #1;
      out_if.out_ready = 1'b1;
      @(posedge clk); #1;
      check("t4_x_after_accept", 64'({out_if.out_valid, out_if.out_x}), 64'd1);
      wait_frame_done();
      idle_check();

      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
